// File: rtl/axi_ni_write_beat_sequencer_if.sv
// Command, payload and AXI W signals of the NI write beat sequencer.
// Every channel transfers on a rising clock edge where valid and ready are both high;
// a source holds valid and its payload steady until that edge, and ready may depend on valid.
interface axi_ni_write_beat_sequencer_if #(
    parameter int AXIWDATAWD = 32,
    parameter int LENWD      = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [LENWD-1:0]          cmd_len;
    logic [AXIWDATAWD/8-1:0]   cmd_wstrb;

    logic                      pld_valid;
    logic                      pld_ready;
    logic [AXIWDATAWD-1:0]     pld_data;
    logic [AXIWDATAWD/8-1:0]   pld_be;

    logic                      WVALID;
    logic                      WREADY;
    logic [AXIWDATAWD-1:0]     WDATA;
    logic [AXIWDATAWD/8-1:0]   WSTRB;
    logic                      WLAST;
    logic                      burst_done;

    modport slave (
        input  cmd_valid, cmd_len, cmd_wstrb,
        input  pld_valid, pld_data, pld_be,
        input  WREADY,
        output cmd_ready, pld_ready,
        output WVALID, WDATA, WSTRB, WLAST, burst_done
    );

    modport master (
        output cmd_valid, cmd_len, cmd_wstrb,
        output pld_valid, pld_data, pld_be,
        output WREADY,
        input  cmd_ready, pld_ready,
        input  WVALID, WDATA, WSTRB, WLAST, burst_done
    );
endinterface

// File: rtl/axi_ni_write_beat_sequencer.sv
// Turns one burst command plus a payload beat stream into AXI W beats with WSTRB/WLAST.
// Define AXI_NI_W_SKID_EN to register W through a 2-entry skid buffer; default is pass-through.
module axi_ni_write_beat_sequencer #(
    parameter int AXIWDATAWD = 32,
    parameter int LENWD      = 8
) (
    input  logic                              clock,
    input  logic                              reset_n,
    axi_ni_write_beat_sequencer_if.slave      bus,
    output logic                              dbg_state_o
);
    localparam int SW = AXIWDATAWD / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e           state_q;
    logic [LENWD-1:0] len_q;
    logic [LENWD-1:0] cnt_q;
    logic [SW-1:0]    wstrb_q;
    logic             done_q;

    logic             cmd_fire;
    logic             pld_fire;
    logic             w_fire;
    logic             beat_last;
    logic [SW-1:0]    beat_strb;

    assign bus.cmd_ready  = (state_q == IDLE);
    assign cmd_fire       = bus.cmd_valid & bus.cmd_ready;
    assign pld_fire       = bus.pld_valid & bus.pld_ready;
    assign w_fire         = bus.WVALID & bus.WREADY;
    // Equality against the latched length never needs a wider counter: a full-range
    // burst ends on cnt_q == all-ones and leaves BURST before the counter could wrap.
    assign beat_last      = (cnt_q == len_q);
    assign beat_strb      = wstrb_q & bus.pld_be;
    assign bus.burst_done = done_q;
    assign dbg_state_o    = (state_q == BURST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wstrb_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= w_fire & bus.WLAST;
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        len_q   <= bus.cmd_len;
                        wstrb_q <= bus.cmd_wstrb;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (pld_fire) begin
                        if (beat_last) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + LENWD'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_NI_W_SKID_EN
    localparam int EW = AXIWDATAWD + SW + 1;

    logic [EW-1:0] buf_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;
    logic [EW-1:0] head;

    // Ready looks only at registered occupancy, so WREADY never reaches pld_ready.
    assign bus.pld_ready = (state_q == BURST) & (occ_q != 2'd2);
    assign bus.WVALID    = (occ_q != 2'd0);
    assign head          = bus.WVALID ? buf_q[rd_ptr_q] : '0;
    assign {bus.WDATA, bus.WSTRB, bus.WLAST} = head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (pld_fire) begin
                buf_q[wr_ptr_q] <= {bus.pld_data, beat_strb, beat_last};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({pld_fire, w_fire})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end
`else
    // Pass-through: a payload beat is the W beat, so both sides share one handshake.
    assign bus.pld_ready = (state_q == BURST) & bus.WREADY;
    assign bus.WVALID    = (state_q == BURST) & bus.pld_valid;
    assign bus.WDATA     = bus.WVALID ? bus.pld_data : '0;
    assign bus.WSTRB     = bus.WVALID ? beat_strb : '0;
    assign bus.WLAST     = bus.WVALID & beat_last;
`endif
endmodule

// File: tb/tb_axi_ni_write_beat_sequencer.sv
// Directed bench for axi_ni_write_beat_sequencer: queue-driven command/payload drivers,
// a burst-level model of expected W beats, and one per-cycle compare process.
module tb_axi_ni_write_beat_sequencer;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 8;
    localparam int EW = DW + SW + 1;

    logic clock = 1'b0;
    logic reset_n;
    logic dbg_state;

    axi_ni_write_beat_sequencer_if #(.AXIWDATAWD(DW), .LENWD(LW)) bus_if ();

    axi_ni_write_beat_sequencer #(.AXIWDATAWD(DW), .LENWD(LW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus_if.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [LW+SW-1:0] cmd_q[$];
    logic [DW+SW-1:0] pld_q[$];
    logic [EW-1:0]    exp_q[$];

    bit cmd_hold = 1'b0;
    bit wr_rand  = 1'b0;

    bit            busy        = 1'b0;
    int            beats_left  = 0;
    int            beats_taken = 0;
    int            occ         = 0;
    bit            done_exp    = 1'b0;
    bit            stall_prev  = 1'b0;
    bit            acc_prev    = 1'b0;
    logic [EW-1:0] prev_w      = '0;
    logic [EW-1:0] last_w      = '0;
    int            w_cnt       = 0;
    int            wlast_cnt   = 0;
    int            wlast_pos   = 0;
    int            done_cnt    = 0;
    int            cmd_acc_hist[$];
    int            last_acc_hist[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    initial begin : driver
        bit cf;
        bit pf;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_len   = '0;
        bus_if.cmd_wstrb = '0;
        bus_if.pld_valid = 1'b0;
        bus_if.pld_data  = '0;
        bus_if.pld_be    = '0;
        bus_if.WREADY    = 1'b0;
        forever begin
            @(negedge clock);
            cf = bus_if.cmd_valid & bus_if.cmd_ready;
            pf = bus_if.pld_valid & bus_if.pld_ready;
            @(posedge clock);
            #1;
            if (cf && cmd_q.size() > 0) void'(cmd_q.pop_front());
            if (pf && pld_q.size() > 0) void'(pld_q.pop_front());
            if (cmd_q.size() > 0 && !cmd_hold) begin
                bus_if.cmd_valid = 1'b1;
                {bus_if.cmd_len, bus_if.cmd_wstrb} = cmd_q[0];
            end else begin
                bus_if.cmd_valid = 1'b0;
                bus_if.cmd_len   = '0;
                bus_if.cmd_wstrb = '0;
            end
            if (pld_q.size() > 0) begin
                bus_if.pld_valid = 1'b1;
                {bus_if.pld_data, bus_if.pld_be} = pld_q[0];
            end else begin
                bus_if.pld_valid = 1'b0;
                bus_if.pld_data  = '0;
                bus_if.pld_be    = '0;
            end
            bus_if.WREADY = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Queues one command and its len+1 payload beats; the expected W beat carries the
    // payload data, strobe = command strobe AND beat enables, last on beat index len.
    task automatic add_burst(input int len, input logic [SW-1:0] wstrb,
                             input logic [SW-1:0] be_fixed, input bit be_rand);
        logic [DW-1:0] d;
        logic [SW-1:0] be;
        cmd_q.push_back({LW'(len), wstrb});
        for (int i = 0; i <= len; i++) begin
            d  = $urandom();
            be = be_rand ? SW'($urandom_range(0, 15)) : be_fixed;
            pld_q.push_back({d, be});
            exp_q.push_back({d, wstrb & be, (i == len)});
        end
    endtask

    task automatic clear_stats();
        w_cnt     = 0;
        wlast_cnt = 0;
        wlast_pos = 0;
        done_cnt  = 0;
        cmd_acc_hist.delete();
        last_acc_hist.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #2;
            if (exp_q.size() == 0 && cmd_q.size() == 0 && pld_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"drain_", name}, 64'(ok), 64'd1);
        repeat (3) @(posedge clock);
        #2;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin : compare
        bit            cf;
        bit            acc;
        bit            wf;
        logic [EW-1:0] cur_w;
        logic [EW-1:0] e;
        cur_w = {bus_if.WDATA, bus_if.WSTRB, bus_if.WLAST};
        if (!reset_n) begin
            chk("rst_wvalid",     64'(bus_if.WVALID),     64'd0);
            chk("rst_wlast",      64'(bus_if.WLAST),      64'd0);
            chk("rst_wdata",      64'(bus_if.WDATA),      64'd0);
            chk("rst_wstrb",      64'(bus_if.WSTRB),      64'd0);
            chk("rst_burst_done", 64'(bus_if.burst_done), 64'd0);
            chk("rst_pld_ready",  64'(bus_if.pld_ready),  64'd0);
            chk("rst_cmd_ready",  64'(bus_if.cmd_ready),  64'd1);
            busy       = 1'b0;
            beats_left = 0;
            occ        = 0;
            done_exp   = 1'b0;
            stall_prev = 1'b0;
            acc_prev   = 1'b0;
        end else begin
            chk("burst_done", 64'(bus_if.burst_done), 64'(done_exp));
            chk("cmd_ready",  64'(bus_if.cmd_ready),  64'(!busy));
            chk("dbg_state",  64'(dbg_state),         64'(busy));
`ifdef AXI_NI_W_SKID_EN
            chk("pld_ready_skid", 64'(bus_if.pld_ready), 64'(busy && occ < 2));
            chk("wvalid_skid",    64'(bus_if.WVALID),    64'(occ > 0));
            if (acc_prev) chk("skid_latency", 64'(bus_if.WVALID), 64'd1);
`else
            chk("pld_ready_pt", 64'(bus_if.pld_ready), 64'(busy && bus_if.WREADY));
            chk("wvalid_pt",    64'(bus_if.WVALID),    64'(busy && bus_if.pld_valid));
`endif
            if (stall_prev) begin
                chk("stall_wvalid", 64'(bus_if.WVALID), 64'd1);
                chk("stall_wbeat",  64'(cur_w),         64'(prev_w));
            end
            done_exp = 1'b0;
            wf = bus_if.WVALID & bus_if.WREADY;
            if (wf) begin
                w_cnt++;
                last_w = cur_w;
                if (bus_if.WLAST) begin
                    wlast_cnt++;
                    wlast_pos = w_cnt;
                end
                if (exp_q.size() == 0) begin
                    chk("w_unexpected_beat", 64'(cur_w), 64'd0);
                    checks++;
                    failures++;
                    $display("FAIL w_extra_beat actual=0x%0h expected=none", cur_w);
                end else begin
                    e = exp_q.pop_front();
                    chk("w_data", 64'(bus_if.WDATA), 64'(e[EW-1:SW+1]));
                    chk("w_strb", 64'(bus_if.WSTRB), 64'(e[SW:1]));
                    chk("w_last", 64'(bus_if.WLAST), 64'(e[0]));
                    done_exp = e[0];
                end
            end
            if (bus_if.burst_done) done_cnt++;
            stall_prev = bus_if.WVALID & !bus_if.WREADY;
            prev_w     = cur_w;

            // Predict what the coming rising edge transfers.
            cf  = bus_if.cmd_valid & bus_if.cmd_ready;
            acc = busy & bus_if.pld_valid & bus_if.pld_ready;
            if (cf) begin
                busy        = 1'b1;
                beats_left  = int'(bus_if.cmd_len) + 1;
                beats_taken = 0;
                cmd_acc_hist.push_back(cycle);
            end else if (acc) begin
                beats_left--;
                beats_taken++;
                if (beats_left == 0) begin
                    busy = 1'b0;
                    last_acc_hist.push_back(cycle);
                end
            end
            occ      = occ + (acc ? 1 : 0) - (wf ? 1 : 0);
            acc_prev = acc;
        end
    end

    // ---------------- directed tests ----------------
    initial begin : main
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        chk("post_reset_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

        // 4-beat burst, full strobes.
        clear_stats();
        add_burst(3, 4'hF, 4'hF, 1'b0);
        wait_drain("len3", 200);
        chk("len3_beats",     64'(w_cnt),     64'd4);
        chk("len3_wlasts",    64'(wlast_cnt), 64'd1);
        chk("len3_wlast_pos", 64'(wlast_pos), 64'd4);
        chk("len3_done",      64'(done_cnt),  64'd1);
        chk("len3_last_strb", 64'(last_w[SW:1]), 64'hF);
        chk("len3_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

        // Single beat, strobe intersection 0x3 & 0xE = 0x2.
        clear_stats();
        add_burst(0, 4'h3, 4'hE, 1'b0);
        wait_drain("len0", 100);
        chk("len0_beats", 64'(w_cnt),        64'd1);
        chk("len0_strb",  64'(last_w[SW:1]), 64'h2);
        chk("len0_last",  64'(last_w[0]),    64'd1);
        chk("len0_done",  64'(done_cnt),     64'd1);

        // Payload offered while idle must not be consumed.
        clear_stats();
        cmd_hold = 1'b1;
        add_burst(2, 4'hF, 4'h0, 1'b1);
        repeat (6) @(posedge clock);
        #2;
        chk("idle_no_w",      64'(w_cnt),        64'd0);
        chk("idle_pld_kept",  64'(pld_q.size()), 64'd3);
        cmd_hold = 1'b0;
        wait_drain("idle_then_go", 100);
        chk("idle_then_beats", 64'(w_cnt), 64'd3);

        // Full-range burst: 256 beats, no counter wrap.
        clear_stats();
        add_burst(255, 4'hF, 4'hF, 1'b0);
        wait_drain("len255", 800);
        chk("len255_beats",     64'(w_cnt),     64'd256);
        chk("len255_wlasts",    64'(wlast_cnt), 64'd1);
        chk("len255_wlast_pos", 64'(wlast_pos), 64'd256);
        chk("len255_done",      64'(done_cnt),  64'd1);

        // Random W backpressure.
        clear_stats();
        wr_rand = 1'b1;
        add_burst(7, 4'hA, 4'h0, 1'b1);
        wait_drain("len7_stall", 400);
        wr_rand = 1'b0;
        chk("len7_beats",  64'(w_cnt),     64'd8);
        chk("len7_wlasts", 64'(wlast_cnt), 64'd1);
        chk("len7_done",   64'(done_cnt),  64'd1);

        // Back-to-back commands with cmd_valid held across the last beat.
        clear_stats();
        add_burst(1, 4'hF, 4'hF, 1'b0);
        add_burst(2, 4'h5, 4'hF, 1'b0);
        wait_drain("b2b", 200);
        chk("b2b_cmds",   64'(cmd_acc_hist.size()), 64'd2);
        if (cmd_acc_hist.size() == 2 && last_acc_hist.size() >= 1)
            chk("b2b_bubble", 64'(cmd_acc_hist[1]), 64'(last_acc_hist[0] + 1));
        chk("b2b_beats",  64'(w_cnt),     64'd5);
        chk("b2b_wlasts", 64'(wlast_cnt), 64'd2);
        chk("b2b_done",   64'(done_cnt),  64'd2);

        // Reset after beat 2 of an 8-beat burst.
        clear_stats();
        begin : mid_reset
            bit hit;
            hit = 1'b0;
            add_burst(7, 4'hF, 4'hF, 1'b0);
            for (int i = 0; i < 100; i++) begin
                @(posedge clock);
                #2;
                if (busy && beats_taken == 2) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("mid_reset_reached", 64'(hit), 64'd1);
        end
        reset_n = 1'b0;
        cmd_q.delete();
        pld_q.delete();
        exp_q.delete();
        bus_if.cmd_valid = 1'b0;
        bus_if.pld_valid = 1'b0;
        #1;
        chk("async_rst_wvalid",    64'(bus_if.WVALID),     64'd0);
        chk("async_rst_wlast",     64'(bus_if.WLAST),      64'd0);
        chk("async_rst_wdata",     64'(bus_if.WDATA),      64'd0);
        chk("async_rst_wstrb",     64'(bus_if.WSTRB),      64'd0);
        chk("async_rst_done",      64'(bus_if.burst_done), 64'd0);
        chk("async_rst_pld_ready", 64'(bus_if.pld_ready),  64'd0);
        chk("async_rst_cmd_ready", 64'(bus_if.cmd_ready),  64'd1);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        chk("mid_reset_no_wlast", 64'(wlast_cnt), 64'd0);
        chk("mid_reset_no_done",  64'(done_cnt),  64'd0);

        clear_stats();
        add_burst(3, 4'hC, 4'h0, 1'b1);
        wait_drain("after_reset", 200);
        chk("after_reset_beats",  64'(w_cnt),     64'd4);
        chk("after_reset_wlasts", 64'(wlast_cnt), 64'd1);
        chk("after_reset_done",   64'(done_cnt),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #300000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
